// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// carrying between chunks through a register. Results are published only on completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cin,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v
);

    localparam int K  = WIDTH / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [CHUNK-1:0] x_chunk_s;
    logic [CHUNK-1:0] y_chunk_s;
    logic [CHUNK-1:0] sum_chunk_s;
    logic             carry_out_s;
    logic             carry_msb_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             v_r;

    assign last_s = (cnt_r == LAST_STEP);

    // State register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; DONE accepts a new start just like IDLE
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (in_start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One chunk of ripple addition; the MSB carry-in is recovered from the top sum bit
    always_comb begin
        x_chunk_s                  = x_r[CHUNK-1:0];
        y_chunk_s                  = y_r[CHUNK-1:0];
        {carry_out_s, sum_chunk_s} = {1'b0, x_chunk_s} + {1'b0, y_chunk_s}
                                   + {{CHUNK{1'b0}}, carry_r};
        carry_msb_s                = sum_chunk_s[CHUNK-1] ^ x_chunk_s[CHUNK-1]
                                   ^ y_chunk_s[CHUNK-1];
        acc_next_s                 = WIDTH'({sum_chunk_s, acc_r} >> CHUNK);
    end

    // Operand shifters, carry and step counter; new chunks enter the result from the top
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            x_r     <= in_x;
            y_r     <= in_sub ? ~in_y : in_y;
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= in_sub ? 1'b1 : in_cin;
            cnt_r   <= {CW{1'b0}};
        end else if (step_s) begin
            x_r     <= x_r >> CHUNK;
            y_r     <= y_r >> CHUNK;
            acc_r   <= acc_next_s;
            carry_r <= carry_out_s;
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            x_r     <= x_r;
            y_r     <= y_r;
            acc_r   <= acc_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered outputs; the result is published only on the final step
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            v_r    <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
            if (step_s && last_s) begin
                s_r <= acc_next_s;
                c_r <= carry_out_s;
                v_r <= carry_msb_s ^ carry_out_s;
            end else begin
                s_r <= s_r;
                c_r <= c_r;
                v_r <= v_r;
            end
        end
    end

    assign out_busy = busy_r;
    assign out_done = done_r;
    assign out_s    = s_r;
    assign out_c    = c_r;
    assign out_v    = v_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (1/1, 8/1, 8/4) driven
// from a vector table, hand-written handshake/reset sequences and random traffic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_b, y_b;
    logic       sub_b, cin_b;
    logic       start1, start8, start4;

    logic       busy1, done1, c1, v1;
    logic [0:0] s1;
    logic       busy8, done8, c8, v8;
    logic [7:0] s8;
    logic       busy4, done4, c4, v4;
    logic [7:0] s4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_start(start1), .in_sub(sub_b),
        .in_x(x_b[0:0]), .in_y(y_b[0:0]), .in_cin(cin_b),
        .out_busy(busy1), .out_done(done1), .out_s(s1), .out_c(c1), .out_v(v1)
    );

    serial_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
        .in_clk(clk), .in_rst(rst), .in_start(start8), .in_sub(sub_b),
        .in_x(x_b), .in_y(y_b), .in_cin(cin_b),
        .out_busy(busy8), .out_done(done8), .out_s(s8), .out_c(c8), .out_v(v8)
    );

    serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
        .in_clk(clk), .in_rst(rst), .in_start(start4), .in_sub(sub_b),
        .in_x(x_b), .in_y(y_b), .in_cin(cin_b),
        .out_busy(busy4), .out_done(done4), .out_s(s4), .out_c(c4), .out_v(v4)
    );

    typedef struct {
        int         which;
        logic [7:0] x;
        logic [7:0] y;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int klat(input int which);
        return (which == 1) ? 1 : ((which == 8) ? 8 : 2);
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                         input logic sub, input logic cin);
        int m    = 1 << w;
        int xu   = int'(x) % m;
        int yu   = int'(y) % m;
        int ci   = sub ? 0 : int'(cin);
        int full = sub ? (xu - yu + m) : (xu + yu + ci);
        int xs   = (xu >= m / 2) ? xu - m : xu;
        int ys   = (yu >= m / 2) ? yu - m : yu;
        int r    = sub ? (xs - ys) : (xs + ys + ci);
        logic [7:0] s_m = 8'(full % m);
        logic       c_m = (full >= m);
        logic       v_m = (r >= m / 2) || (r < -(m / 2));
        return {v_m, c_m, s_m};
    endfunction

    task automatic get_out(input int which, output logic d, output logic b,
                           output logic [7:0] s, output logic c, output logic v);
        case (which)
            1:       begin d = done1; b = busy1; s = {7'b0, s1}; c = c1; v = v1; end
            8:       begin d = done8; b = busy8; s = s8;         c = c8; v = v8; end
            default: begin d = done4; b = busy4; s = s4;         c = c4; v = v4; end
        endcase
    endtask

    task automatic set_start(input int which, input logic val);
        case (which)
            1:       start1 = val;
            8:       start8 = val;
            default: start4 = val;
        endcase
    endtask

    task automatic launch(input int which, input logic [7:0] x, input logic [7:0] y,
                          input logic sub, input logic cin);
        x_b = x; y_b = y; sub_b = sub; cin_b = cin;
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
    endtask

    // Called after the start edge plus 'elapsed' further edges; stops in the DONE cycle
    task automatic finish_check(input string name, input int which, input int elapsed,
                                input logic [7:0] es, input logic ec, input logic ev);
        int   got = -1;
        int   lat = klat(which);
        logic busy_bad = 1'b0;
        logic d, b, c, v;
        logic [7:0] s;
        get_out(which, d, b, s, c, v);
        if (!b || d) busy_bad = 1'b1;
        for (int cyc = elapsed + 1; cyc <= lat + 4 && got < 0; cyc++) begin
            @(posedge clk); #1;
            get_out(which, d, b, s, c, v);
            if (d) begin
                got = cyc;
                if (b) busy_bad = 1'b1;
            end else if (!b && cyc <= lat) begin
                busy_bad = 1'b1;
            end
        end
        chk({name, "/latency"}, 32'(got), 32'(lat));
        chk({name, "/busy"}, 32'(busy_bad), 32'(0));
        chk({name, "/s"}, 32'(s), 32'(es));
        chk({name, "/c"}, 32'(c), 32'(ec));
        chk({name, "/v"}, 32'(v), 32'(ev));
    endtask

    initial begin
        vec_t       tbl[$];
        logic [9:0] m;
        logic       d, b, c, v;
        logic [7:0] s;
        logic       saw_done, saw_busy;
        int         which;

        // Reset with random inputs and start held high on every instance
        rst = 1'b1;
        start1 = 1'b1; start8 = 1'b1; start4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x_b = 8'($urandom); y_b = 8'($urandom);
            sub_b = 1'($urandom); cin_b = 1'($urandom);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            which = (k == 0) ? 1 : ((k == 1) ? 8 : 4);
            get_out(which, d, b, s, c, v);
            chk($sformatf("reset%0d/outs", which), {20'(0), d, b, s, c, v}, 32'(0));
        end
        start1 = 1'b0; start8 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset/busy", {29'(0), busy1, busy8, busy4}, 32'(0));

        // Directed vectors: full-adder truth table, add boundaries, subtract
        tbl.push_back('{1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1});
        tbl.push_back('{1, 8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{1, 8'h01, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{8, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{8, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{8, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{4, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{4, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1});
        tbl.push_back('{4, 8'h3C, 8'h4A, 1'b0, 1'b1, 8'h87, 1'b0, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            launch(tbl[i].which, tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].cin);
            finish_check($sformatf("vec%0d", i), tbl[i].which, 0, tbl[i].s, tbl[i].c, tbl[i].v);
            @(posedge clk); #1;
        end

        // Random traffic; skipping the idle cycle on the same instance exercises back-to-back starts
        for (int i = 0; i < 60; i++) begin
            int   sel = int'($urandom_range(0, 2));
            logic [7:0] rx = 8'($urandom);
            logic [7:0] ry = 8'($urandom);
            logic rs = 1'($urandom);
            logic rc = 1'($urandom);
            which = (sel == 0) ? 1 : ((sel == 1) ? 8 : 4);
            m = model((which == 1) ? 1 : 8, rx, ry, rs, rc);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            launch(which, rx, ry, rs, rc);
            finish_check($sformatf("rand%0d", i), which, 0, m[7:0], m[8], m[9]);
        end
        @(posedge clk); #1;

        // Start pulsed mid-run is ignored; result register holds until completion
        launch(8, 8'h11, 8'h22, 1'b0, 1'b0);
        finish_check("hold_setup", 8, 0, 8'h33, 1'b0, 1'b0);
        @(posedge clk); #1;
        launch(8, 8'h5A, 8'h33, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("hold/s_mid_run", 32'(s8), 32'h33);
        @(posedge clk); #1;
        x_b = 8'hFF; y_b = 8'hFF; sub_b = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        finish_check("midrun_start", 8, 3, 8'h8D, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("midrun_start/idle_after", {30'(0), busy8, done8}, 32'(0));

        // Start accepted in the DONE cycle
        launch(4, 8'h05, 8'h07, 1'b1, 1'b1);
        finish_check("b2b_first", 4, 0, 8'hFE, 1'b0, 1'b0);
        launch(4, 8'h80, 8'h01, 1'b1, 1'b0);
        finish_check("b2b_second", 4, 0, 8'h7F, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Reset in the fourth cycle of an 8-step add aborts it
        launch(8, 8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst/outs", {20'(0), done8, busy8, s8, c8, v8}, 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            saw_done = saw_done | done8;
            saw_busy = saw_busy | busy8;
        end
        chk("midrst/no_done", 32'(saw_done), 32'(0));
        chk("midrst/no_busy", 32'(saw_busy), 32'(0));
        launch(8, 8'h12, 8'h34, 1'b0, 1'b0);
        finish_check("after_rst", 8, 0, 8'h46, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
